// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between the fetch (I) and load/store (D) pipeline stages.
// Latency: req sampled at E0, mem_en in E0..E1, rvalid in E(1+MEM_LAT)..E(2+MEM_LAT); one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req until rvalid; stall_if/stall_mem tell hazard logic a side is waiting.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX data grants with fetch pending, fetch is granted once.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  // fetch side
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  // pipeline hazard interface
  output logic                stall_if,
  output logic                stall_mem,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // captured request, replayed onto the memory port during ISSUE
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_t      state;
  state_t      state_nxt;
  req_t        cap;
  logic        owner_d;      // 1 = data side owns the transaction in flight
  logic [3:0]  lat_cnt;
  logic        lat_done;
  logic        grant_d;
  logic        grant_i;
  logic        starve_force; // fetch must win the next arbitration

  assign lat_done = (lat_cnt == 4'(MEM_LAT));

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  // count data grants taken while fetch was waiting; any fetch grant clears the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_i) begin
      starve_cnt <= 4'd0;
    end else if (grant_d && i_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign starve_force = i_req && (starve_cnt == 4'(STARVE_MAX));
`else
  // strict data priority: the limit has no effect in this build
  localparam int unused_starve_max = STARVE_MAX;
  assign starve_force = 1'b0;
`endif

  // arbitration, only meaningful in IDLE: data first unless fetch has been starved
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (d_req && !starve_force) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic: IDLE -> ISSUE -> WAIT (MEM_LAT edges) -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the memory strobe and the owner's grant live only in ISSUE
  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    i_gnt  = 1'b0;
    d_gnt  = 1'b0;
    busy   = 1'b0;
    case (state)
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = owner_d && cap.we;
        i_gnt  = !owner_d;
        d_gnt  = owner_d;
        busy   = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // capture the winning request; fetches are reads, so write fields are zeroed
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap     <= '0;
      owner_d <= 1'b0;
    end else if (grant_d) begin
      cap.we    <= d_we;
      cap.addr  <= d_addr;
      cap.wdata <= d_we ? d_wdata : '0;
      cap.wstrb <= d_we ? d_wstrb : '0;
      owner_d   <= 1'b1;
    end else if (grant_i) begin
      cap.we    <= 1'b0;
      cap.addr  <= i_addr;
      cap.wdata <= '0;
      cap.wstrb <= '0;
      owner_d   <= 1'b0;
    end
  end

  // latency counter: 1 on entering WAIT, advances until it reaches MEM_LAT
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_cnt <= 4'd0;
    end else if (state == ISSUE) begin
      lat_cnt <= 4'd1;
    end else if (state == WAIT) begin
      lat_cnt <= lat_done ? 4'd0 : lat_cnt + 4'd1;
    end
  end

  // response capture: one-cycle rvalid to the owner; stores leave d_rdata untouched
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (state == WAIT && lat_done) begin
        if (owner_d) begin
          d_rvalid <= 1'b1;
          if (!cap.we) d_rdata <= mem_rdata;
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = cap.addr;
  assign mem_wdata = cap.wdata;
  assign mem_wstrb = cap.wstrb;

  // a side stalls the pipeline until its completion pulse arrives
  assign stall_if  = i_req && !i_rvalid;
  assign stall_mem = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory device model plus scoreboard queues of expected memory ops and responses.
// Latency: transactions are driven at negedge and their results observed at later negedges.
// Backpressure: requests are held until the matching rvalid is seen, then dropped.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int SM  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall_if, stall_mem, busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        own_d;
  } mem_op_t;

  mem_op_t     exp_mem[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // memory device: word array, read data held from the last read access
  logic [31:0] mem_dev [0:1023];
  logic [9:0]  rd_idx = 10'd0;
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      mem_dev[10'h004] <= 32'h0050_0093; // 0x10
      mem_dev[10'h008] <= 32'h1234_5678; // 0x20
      mem_dev[10'h00C] <= 32'h7777_0003; // 0x30
      mem_dev[10'h010] <= 32'hCAFE_0001; // 0x40
      mem_dev[10'h011] <= 32'h0BAD_0002; // 0x44
      mem_dev[10'h040] <= 32'h0000_00AA; // 0x100
      mem_dev[10'h080] <= 32'h1111_2222; // 0x200
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem_dev[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_idx <= mem_addr[11:2];
      end
    end
  end

  assign mem_rdata = mem_dev[rd_idx];

  // run the scoreboard until every expected op/response is consumed or the budget expires
  task automatic drain(input int budget, output int en_cnt, output int en1,
                       output int i_cyc, output int d_cyc, output int stall_i);
    mem_op_t     op;
    logic [31:0] ed;
    logic [70:0] act_v, exp_v;
    int k;
    en_cnt = 0; en1 = 0; i_cyc = 0; d_cyc = 0; stall_i = 0; k = 0;
    while (k < budget && (exp_mem.size() + exp_i.size() + exp_d.size()) != 0) begin
      @(negedge clk);
      k++;
      if (stall_if) stall_i++;
      if (mem_en) begin
        en_cnt++;
        if (en1 == 0) en1 = k;
        total++;
        if (exp_mem.size() == 0) begin
          bad++;
          $display("FAIL mem_op: unexpected mem_en addr=%h, none expected", mem_addr);
        end else begin
          op    = exp_mem.pop_front();
          act_v = {mem_we, mem_addr, mem_wstrb, (mem_we ? mem_wdata : 32'h0), d_gnt, i_gnt};
          exp_v = {op.we, op.addr, op.wstrb, op.wdata, op.own_d, !op.own_d};
          if (act_v !== exp_v) begin
            bad++;
            $display("FAIL mem_op: got we/addr/strb/wdata/dg/ig=%h want %h", act_v, exp_v);
          end
        end
      end
      if (i_rvalid) begin
        if (i_cyc == 0) i_cyc = k;
        total++;
        if (exp_i.size() == 0) begin
          bad++;
          $display("FAIL i_resp: unexpected i_rvalid rdata=%h", i_rdata);
        end else begin
          ed = exp_i.pop_front();
          if (i_rdata !== ed) begin
            bad++;
            $display("FAIL i_rdata: got %h want %h", i_rdata, ed);
          end
        end
        i_req = 1'b0;
      end
      if (d_rvalid) begin
        if (d_cyc == 0) d_cyc = k;
        total++;
        if (exp_d.size() == 0) begin
          bad++;
          $display("FAIL d_resp: unexpected d_rvalid rdata=%h", d_rdata);
        end else begin
          ed = exp_d.pop_front();
          if (d_rdata !== ed) begin
            bad++;
            $display("FAIL d_rdata: got %h want %h", d_rdata, ed);
          end
        end
        d_req = 1'b0;
        d_we  = 1'b0;
      end
    end
    if ((exp_mem.size() + exp_i.size() + exp_d.size()) != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: left mem=%0d i=%0d d=%0d want 0", exp_mem.size(), exp_i.size(), exp_d.size());
      exp_mem.delete();
      exp_i.delete();
      exp_d.delete();
    end
  endtask

  task automatic test_reset();
    int en_cnt, en1, ic, dc, st;
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0; d_wstrb = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({mem_en, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, i_rdata, d_rdata, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
        bad++;
        $display("FAIL reset_outs[%0d]: en=%b ig=%b dg=%b irv=%b drv=%b busy=%b ird=%h drd=%h ma=%h want all 0",
                 c, mem_en, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, i_rdata, d_rdata, mem_addr);
      end
    end
    // first edge sampling reset=1 arbitrates: D then I
    exp_mem.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0, own_d: 1'b1});
    exp_mem.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0, wstrb: 4'h0, own_d: 1'b0});
    exp_d.push_back(32'hCAFE_0001);
    exp_i.push_back(32'h0BAD_0002);
    reset = 1'b1;
    drain(40, en_cnt, en1, ic, dc, st);
    total++;
    if (en1 !== 1) begin
      bad++;
      $display("FAIL reset_first_grant: mem_en first seen in cycle %0d want 1", en1);
    end
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int en_cnt, en1, ic, dc, st;
    i_req = 1'b1; i_addr = 32'h10;
    exp_mem.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, wstrb: 4'h0, own_d: 1'b0});
    exp_i.push_back(32'h0050_0093);
    drain(40, en_cnt, en1, ic, dc, st);
    total++;
    if (en_cnt !== 1) begin bad++; $display("FAIL fetch_en_count: got %0d want 1", en_cnt); end
    total++;
    if (ic !== LAT + 2) begin bad++; $display("FAIL fetch_latency: i_rvalid cycle %0d want %0d", ic, LAT + 2); end
    total++;
    if (st !== LAT + 1) begin bad++; $display("FAIL fetch_stall: stall_if cycles %0d want %0d", st, LAT + 1); end
    @(negedge clk);
  endtask

  task automatic test_priority();
    int en_cnt, en1, ic, dc, st;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    exp_mem.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0, own_d: 1'b1});
    exp_mem.push_back('{we: 1'b0, addr: 32'h20,  wdata: 32'h0, wstrb: 4'h0, own_d: 1'b0});
    exp_d.push_back(32'h0000_00AA);
    exp_i.push_back(32'h1234_5678);
    drain(60, en_cnt, en1, ic, dc, st);
    total++;
    if (en_cnt !== 2) begin bad++; $display("FAIL prio_en_count: got %0d want 2", en_cnt); end
    total++;
    if (dc !== LAT + 2) begin bad++; $display("FAIL prio_d_latency: d_rvalid cycle %0d want %0d", dc, LAT + 2); end
    total++;
    if (ic - dc !== LAT + 2) begin bad++; $display("FAIL prio_i_after_d: gap %0d want %0d", ic - dc, LAT + 2); end
    @(negedge clk);
  endtask

  task automatic test_store();
    int en_cnt, en1, ic, dc, st;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    exp_mem.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF, wstrb: 4'b0011, own_d: 1'b1});
    exp_d.push_back(32'h0000_00AA); // store leaves load data from the previous load
    drain(40, en_cnt, en1, ic, dc, st);
    total++;
    if (en_cnt !== 1) begin bad++; $display("FAIL store_en_count: got %0d want 1", en_cnt); end
    total++;
    if (mem_dev[10'h080] !== 32'h1111_BEEF) begin
      bad++;
      $display("FAIL store_mem_word: got %h want 1111beef", mem_dev[10'h080]);
    end
    d_wdata = 32'h0; d_wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    int en_cnt, en1, ic, dc, st;
    logic seen_rv;
    i_req = 1'b1; i_addr = 32'h30;
    @(negedge clk);
    total++;
    if ({mem_en, i_gnt, mem_addr} !== {1'b1, 1'b1, 32'h30}) begin
      bad++;
      $display("FAIL abort_issue: en=%b ig=%b addr=%h want 1 1 00000030", mem_en, i_gnt, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, i_rvalid, i_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL abort_state: busy=%b irv=%b ird=%h want 0 0 00000000", busy, i_rvalid, i_rdata);
    end
    reset = 1'b1;
    seen_rv = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid || mem_en) seen_rv = 1'b1;
    end
    total++;
    if (seen_rv !== 1'b0) begin bad++; $display("FAIL abort_no_rvalid: activity seen=%b want 0", seen_rv); end
    i_req = 1'b1; i_addr = 32'h10;
    exp_mem.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, wstrb: 4'h0, own_d: 1'b0});
    exp_i.push_back(32'h0050_0093);
    drain(40, en_cnt, en1, ic, dc, st);
    total++;
    if (ic !== LAT + 2) begin bad++; $display("FAIL abort_recover_latency: cycle %0d want %0d", ic, LAT + 2); end
    @(negedge clk);
  endtask

  task automatic test_starve();
    logic gd [0:9];
    logic want_d;
    int n;
    int k;
    n = 0; k = 0;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    while (n < 10 && k < 200) begin
      @(negedge clk);
      k++;
      if (mem_en) begin
        gd[n] = d_gnt;
        n++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    total++;
    if (n !== 10) begin
      bad++;
      $display("FAIL starve_timeout: grants %0d want 10", n);
    end else begin
      for (int g = 0; g < 10; g++) begin
`ifdef ARB_STARVE_GUARD_EN
        want_d = ((g % (SM + 1)) != SM);
`else
        want_d = 1'b1;
`endif
        total++;
        if (gd[g] !== want_d) begin
          bad++;
          $display("FAIL starve_order[%0d]: d_gnt=%b want %b", g, gd[g], want_d);
        end
      end
    end
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_reset_inflight();
    test_starve();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
